// File: rtl/prog_loader.sv
// Boot-time program loader: packs a byte stream into 32-bit words and writes them to instruction memory.
// Optional build macro PROG_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte and an error state.
module prog_loader #(
   parameter int MAX_WORDS = 256,
   parameter int CNT_W     = 9
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] word_count,
   input  logic             halt,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic [31:0]      addr,
   output logic             wr,
   output logic [31:0]      wdata,
   output logic             working,
   output logic             busy,
   output logic             err
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      WRITE   = 3'd2,
      RUN     = 3'd3,
      CSUM    = 3'd4,
      ERROR   = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam state_t DONE = CSUM;
`else
   localparam state_t DONE = RUN;
`endif

   state_t state, next;

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] idx_next;
   logic [CNT_W-1:0] clamp;
   logic [1:0]       bcnt;
   logic [31:0]      shift;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [31:0]      word_full;
   logic             last_byte;

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] sum;
`endif

   assign clamp     = (word_count > MAX_CNT) ? MAX_CNT : word_count;
   assign idx_next  = idx + ONE;
   assign word_full = {shift[23:0], in_data};
   assign last_byte = (bcnt == 2'd3);

   assign addr  = addr_q;
   assign wdata = wdata_q;

   // State register; reset aborts any load in progress.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next;
      end
   end

   // Next-state selection and per-state output strobes.
   always_comb begin
      next     = state;
      in_ready = 1'b0;
      wr       = 1'b0;
      working  = 1'b0;
      busy     = 1'b0;
      err      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               next = (clamp == '0) ? DONE : COLLECT;
            end
         end
         COLLECT: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && last_byte) begin
               next = WRITE;
            end
         end
         WRITE: begin
            wr   = 1'b1;
            busy = 1'b1;
            next = (idx_next == count) ? DONE : COLLECT;
         end
         RUN: begin
            working = 1'b1;
            if (halt) begin
               next = IDLE;
            end
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         CSUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               next = (in_data == sum) ? RUN : ERROR;
            end
         end
         ERROR: begin
            err = 1'b1;
            if (halt) begin
               next = IDLE;
            end
         end
`endif
         default: begin
            next = IDLE;
         end
      endcase
   end

   // Byte packing, word index and the held write address/data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count   <= '0;
         idx     <= '0;
         bcnt    <= '0;
         shift   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  count <= clamp;
                  idx   <= '0;
                  bcnt  <= '0;
               end
            end
            COLLECT: begin
               if (in_valid) begin
                  shift <= word_full;
                  bcnt  <= bcnt + 2'd1;
                  if (last_byte) begin
                     addr_q  <= {{(32-CNT_W){1'b0}}, idx};
                     wdata_q <= word_full;
                  end
               end
            end
            WRITE: begin
               idx  <= idx_next;
               bcnt <= '0;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   // Running mod-256 sum of program bytes, restarted on each load.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sum <= '0;
      end else if (state == IDLE && start) begin
         sum <= '0;
      end else if (state == COLLECT && in_valid) begin
         sum <= sum + in_data;
      end
   end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed load scenarios with random bytes and gaps.
// Expected writes come from a word list built by the bench; captured writes are compared against it.
module tb_prog_loader;

   localparam int CNT_W = 9;
   localparam int MAXW  = 256;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] word_count = '0;
   logic             halt = 1'b0;
   logic             in_valid = 1'b0;
   logic [7:0]       in_data = '0;
   logic             in_ready;
   logic [31:0]      addr;
   logic             wr;
   logic [31:0]      wdata;
   logic             working;
   logic             busy;
   logic             err;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int ready_viol = 0;

   logic [31:0] exp_d[$];
   logic [31:0] got_a[$];
   logic [31:0] got_d[$];
   int          model_sum = 0;

   prog_loader #(.MAX_WORDS(MAXW), .CNT_W(CNT_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .word_count (word_count),
      .halt       (halt),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .addr       (addr),
      .wr         (wr),
      .wdata      (wdata),
      .working    (working),
      .busy       (busy),
      .err        (err)
   );

   always #5 clock = ~clock;

   // Capture every write strobe away from the active edge.
   always @(negedge clock) begin
      if (wr === 1'b1) begin
         got_a.push_back(addr);
         got_d.push_back(wdata);
         if (in_ready !== 1'b0) ready_viol++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input int cnt);
      word_count = CNT_W'(cnt);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic do_halt();
      halt = 1'b1;
      step();
      halt = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom_range(0, 255));
            step();
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("byte_wait", {31'b0, in_ready}, 32'd1);
      step();
   endtask

   // Model: a word is its four bytes most-significant first; the checksum is their sum mod 256.
   task automatic send_word(input logic [31:0] w, input bit gaps);
      logic [7:0] b;
      exp_d.push_back(w);
      for (int k = 0; k < 4; k++) begin
         b = 8'((w / (32'd1 << (24 - 8 * k))) % 256);
         model_sum = (model_sum + int'(b)) % 256;
         send_byte(b, gaps);
      end
   endtask

   task automatic begin_load(input int cnt);
      exp_d.delete();
      got_a.delete();
      got_d.delete();
      model_sum = 0;
      do_start(cnt);
   endtask

   task automatic finish_load();
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(8'(model_sum), 1'b0);
`else
      step();
`endif
      in_valid = 1'b0;
   endtask

   task automatic check_writes(input string tag);
      int n;
      chk({tag, " count"}, 32'(got_d.size()), 32'(exp_d.size()));
      n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, " addr"}, got_a[i], 32'(i));
         chk({tag, " wdata"}, got_d[i], exp_d[i]);
      end
      got_a.delete();
      got_d.delete();
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd0);
      chk({tag, " addr"}, addr, 32'd0);
      chk({tag, " wr"}, {31'b0, wr}, 32'd0);
      chk({tag, " wdata"}, wdata, 32'd0);
      chk({tag, " working"}, {31'b0, working}, 32'd0);
      chk({tag, " busy"}, {31'b0, busy}, 32'd0);
      chk({tag, " err"}, {31'b0, err}, 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) step();
      check_zero_outputs("reset");
      reset = 1'b0;
      step();

      // Eight patterned words
      begin_load(8);
      chk("load8 busy", {31'b0, busy}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         send_word(32'h10F00080 + 32'h00010001 * 32'(i), 1'b0);
         if (i == 0) begin
            chk("latency wr", {31'b0, wr}, 32'd1);
            chk("latency addr", addr, 32'd0);
            chk("latency wdata", wdata, 32'h10F00080);
         end
      end
      finish_load();
      chk("load8 working", {31'b0, working}, 32'd1);
      chk("load8 busy run", {31'b0, busy}, 32'd0);
      chk("load8 in_ready run", {31'b0, in_ready}, 32'd0);
      check_writes("load8");
      do_halt();
      chk("halt working", {31'b0, working}, 32'd0);

      // Random bytes with gaps
      begin_load(8);
      for (int i = 0; i < 8; i++) send_word($urandom(), 1'b1);
      finish_load();
      chk("gaps working", {31'b0, working}, 32'd1);
      check_writes("gaps");
      chk("gaps ready in write", 32'(ready_viol), 32'd0);
      do_start(3);
      repeat (3) step();
      chk("run start ignored", {31'b0, working}, 32'd1);
      chk("run start no wr", 32'(got_d.size()), 32'd0);
      do_halt();

      // Zero count
      begin_load(0);
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(8'h00, 1'b0);
      in_valid = 1'b0;
`endif
      chk("zero working", {31'b0, working}, 32'd1);
      check_writes("zero");
      do_halt();
      chk("zero halt working", {31'b0, working}, 32'd0);
      chk("zero halt busy", {31'b0, busy}, 32'd0);

      // Reset in the middle of word 3
      begin_load(8);
      for (int i = 0; i < 3; i++) send_word($urandom(), 1'b0);
      send_byte(8'h5A, 1'b0);
      send_byte(8'hA5, 1'b0);
      reset = 1'b1;
      #1;
      check_zero_outputs("midreset");
      in_valid = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();
      check_writes("prereset");
      begin_load(1);
      send_word(32'hDEADBEEF, 1'b0);
      finish_load();
      chk("after reset working", {31'b0, working}, 32'd1);
      check_writes("after reset");
      do_halt();

      // Clamped count with a stray start mid-load
      begin_load(300);
      for (int i = 0; i < MAXW; i++) begin
         send_word($urandom(), 1'b0);
         if (i == 10) begin
            in_valid = 1'b0;
            do_start(2);
         end
      end
      finish_load();
      chk("clamp working", {31'b0, working}, 32'd1);
      chk("clamp last addr", (got_a.size() > 0) ? got_a[got_a.size()-1] : 32'hFFFFFFFF, 32'd255);
      check_writes("clamp");
      do_halt();

`ifdef PROG_LOADER_CHECKSUM_EN
      // Checksum accepted
      begin_load(1);
      send_word(32'h01020304, 1'b0);
      step();
      chk("csum busy", {31'b0, busy}, 32'd1);
      chk("csum in_ready", {31'b0, in_ready}, 32'd1);
      chk("csum working", {31'b0, working}, 32'd0);
      send_byte(8'h0A, 1'b0);
      in_valid = 1'b0;
      chk("csum ok working", {31'b0, working}, 32'd1);
      chk("csum ok err", {31'b0, err}, 32'd0);
      check_writes("csum ok");
      do_halt();
      // Checksum rejected
      begin_load(1);
      send_word(32'h01020304, 1'b0);
      send_byte(8'h0B, 1'b0);
      in_valid = 1'b0;
      chk("csum bad err", {31'b0, err}, 32'd1);
      chk("csum bad working", {31'b0, working}, 32'd0);
      chk("csum bad in_ready", {31'b0, in_ready}, 32'd0);
      check_writes("csum bad");
      do_halt();
      chk("csum halt err", {31'b0, err}, 32'd0);
`else
      chk("err tied low", {31'b0, err}, 32'd0);
`endif

      chk("final ready in write", 32'(ready_viol), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader. It is the initiator side of the processor's instruction-load interface (addr / wr / wdata / working).
- It receives a byte stream over a valid/ready handshake, for example from a UART receiver. It packs every 4 bytes into a 32-bit instruction and writes that word into processor instruction memory at consecutive word addresses from 0.
- After the last word it raises `working` to release the processor.
- Sits between the host byte link and the processor top level.

Parameters:
- MAX_WORDS, 256: instruction memory depth in words. A requested `word_count` above this is clamped to MAX_WORDS.
- CNT_W, 9: width of `word_count` and the internal word index. Must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- word_count  in  CNT_W  number of 32-bit words to load; sampled on `start`.
- halt  in  1  returns the block from RUN or ERROR to IDLE and drops `working`.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte-stream ready; a byte is accepted when in_valid & in_ready.
- addr  out  32  instruction memory word address.
- wr  out  1  instruction memory write strobe, exactly one cycle per word.
- wdata  out  32  instruction word.
- working  out  1  processor run enable.
- busy  out  1  high in COLLECT, WRITE and CSUM.
- err  out  1  checksum failure flag; stays 0 when the checksum feature is compiled out.

Behaviour:
- Reset value of every output is 0: in_ready, addr, wr, wdata, working, busy, err. Internal state resets to IDLE, with byte counter 0, word index 0 and shift register 0.
- Reset asserted mid-operation aborts immediately. The partial word is discarded and `wr` never fires afterwards.
- State IDLE:
  - in_ready=0, working=0.
  - start=1 latches min(word_count, MAX_WORDS) and clears the index and byte counter.
  - Count 0: go to RUN (or CSUM when the feature is enabled).
  - Count >0: go to COLLECT.
- State COLLECT:
  - in_ready=1.
  - Each accepted byte shifts in MSB-first: shift <= {shift[23:0], in_data}, and the byte counter increments.
  - When the 4th byte is accepted, go to WRITE.
  - Example: the byte sequence 10 F0 00 80 yields 32'h10F00080.
- State WRITE (exactly 1 cycle):
  - in_ready=0, wr=1, addr = zero-extended word index, wdata = assembled word.
  - Next cycle: index increments and the byte counter clears.
  - If the incremented index equals the count, go to RUN (or CSUM); otherwise go back to COLLECT.
  - addr/wdata hold their last values outside WRITE. `wr` is 0 outside WRITE.
- Write latency: `wr` is asserted in the cycle after the 4th byte handshake.
- Throughput: at most one word per 5 cycles, because in_ready drops during WRITE.
- State RUN:
  - working=1, in_ready=0.
  - `start` is ignored.
  - halt=1 goes to IDLE with working=0 on the next cycle.
- Other `start`/`halt` rules:
  - `start` outside IDLE is ignored.
  - `halt` in COLLECT, WRITE or CSUM is ignored; the load always completes.
- in_valid while in_ready=0 is not consumed; the source must hold the byte.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- When defined:
  - An 8-bit running sum (mod 256) of all accepted program bytes is kept; it is cleared on `start`.
  - After the last WRITE, the block enters state CSUM with in_ready=1 and accepts one further byte.
  - If that byte equals the sum, go to RUN.
  - Otherwise go to ERROR: err=1, working=0, in_ready=0. `halt` returns to IDLE and clears err.
- When not defined:
  - No CSUM or ERROR state; the block goes straight from the last WRITE (or a zero count) to RUN.
  - err is tied to 0.

Test Plan:
- Load 8 words: start with word_count=8, then send bytes forming 32'h10F00080, 32'h10F10081 … 32'h10F70087. Required: eight one-cycle wr pulses with addr 0..7 and the matching wdata; working=1 in the cycle after the 8th WRITE; busy=0 in RUN.
- Backpressure and gaps: randomly deassert in_valid. Required: identical writes, and in_ready=0 in every WRITE cycle with no byte lost.
- Zero count: start with word_count=0. Required: no wr, working=1 one cycle after start; halt then gives working=0 and IDLE.
- Reset mid-word: after 2 bytes of word 3, pulse reset. Required: all outputs 0 immediately, no wr for word 3. A new start with count 1 and bytes DE AD BE EF writes addr 0, wdata 32'hDEADBEEF.
- Clamp and ignore: start with word_count=300 (MAX_WORDS=256). Required: exactly 256 writes, last addr 255. A start pulse issued mid-load has no effect.
- With PROG_LOADER_CHECKSUM_EN: load 1 word 01 02 03 04, then checksum byte 0A. Required: working=1. Repeat with checksum 0B: required err=1, working=0; halt clears err.
